instr_fetch_unit: RTL and testbench

Parametrised, buffered instruction-fetch stage for the simple processor. It generates the PC, issues requests on the instruction-memory req/ack port, and stores returned instructions with their PCs in a prefetch FIFO. The FIFO feeds decode through a valid/ready handshake, and a redirect port restarts fetch at a new PC for branches and jumps. It sits between instruction memory and decode, and replaces the single-register fetch stage.

---
 rtl/instr_fetch_unit.sv | 124 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Buffered instruction-fetch stage: PC generation, req/ack instruction-memory
// port, prefetch FIFO of {pc, instr} toward decode, and a redirect port.

package sp_pkg;
  localparam int unsigned ADDR_WIDTH = 16;
  localparam int unsigned DATA_WIDTH = 16;
endpackage

module instr_fetch_unit #(
  parameter int unsigned    AW        = sp_pkg::ADDR_WIDTH,
  parameter int unsigned    IW        = sp_pkg::DATA_WIDTH,
  parameter int unsigned    PC_STEP   = 2,
  parameter int unsigned    BUF_DEPTH = 4,
  parameter logic [AW-1:0]  RESET_PC  = '0
) (
  input  logic          clk_i,
  input  logic          arst_ni,
  input  logic          enable_i,
  output logic          imem_req_o,
  output logic [AW-1:0] imem_addr_o,
  input  logic          imem_ack_i,
  input  logic [IW-1:0] imem_rdata_i,
  input  logic          redirect_i,
  input  logic [AW-1:0] redirect_pc_i,
  output logic          instr_valid_o,
  input  logic          instr_ready_i,
  output logic [IW-1:0] instr_o,
  output logic [AW-1:0] instr_pc_o
);

  localparam int unsigned   CW         = $clog2(BUF_DEPTH + 1);
  localparam int unsigned   PW         = $clog2(BUF_DEPTH);
  localparam logic [AW-1:0] STEP       = AW'(PC_STEP);
  localparam logic [AW-1:0] ALIGN_MASK = ~AW'(PC_STEP - 1);

  typedef enum logic [1:0] {FETCH, FULL, FLUSH} state_t;

  state_t        state_q;
  logic [AW-1:0] fpc_q;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_q, rd_d, wr_q;
  logic          valid_q;
  logic [AW-1:0] head_pc_q;
  logic [IW-1:0] head_instr_q;
  logic [AW-1:0] pc_mem    [BUF_DEPTH];
  logic [IW-1:0] instr_mem [BUF_DEPTH];
  logic          push, pop, bypass;

  // Request depends only on enable and state; reset forces it low at once
  assign imem_req_o    = arst_ni & enable_i & (state_q == FETCH);
  assign imem_addr_o   = fpc_q;
  assign instr_valid_o = valid_q;
  assign instr_o       = head_instr_q;
  assign instr_pc_o    = head_pc_q;

  // Redirect discards any accept or pop in its cycle
  assign push = imem_req_o & imem_ack_i & ~redirect_i;
  assign pop  = valid_q & instr_ready_i & ~redirect_i;

  // Next occupancy, read pointer and head-bypass select
  always_comb begin
    count_d = count_q;
    rd_d    = rd_q;
    bypass  = 1'b0;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
    if (pop) begin
      rd_d = rd_q + PW'(1);
    end
    // Pushed entry becomes the head when it lands where the head will point
    bypass = push && (wr_q == rd_d);
  end

  // FIFO storage; contents only matter while counted, so no reset
  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem[wr_q]    <= fpc_q;
      instr_mem[wr_q] <= imem_rdata_i;
    end
  end

  // PC, FIFO control, registered head and fetch FSM
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q      <= FETCH;
      fpc_q        <= RESET_PC;
      count_q      <= '0;
      rd_q         <= '0;
      wr_q         <= '0;
      valid_q      <= 1'b0;
      head_pc_q    <= '0;
      head_instr_q <= '0;
    end else if (redirect_i) begin
      state_q <= FLUSH;
      fpc_q   <= redirect_pc_i & ALIGN_MASK;
      count_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      count_q <= count_d;
      rd_q    <= rd_d;
      valid_q <= (count_d != '0);
      if (push) begin
        wr_q  <= wr_q + PW'(1);
        fpc_q <= fpc_q + STEP;
      end
      if (count_d != '0) begin
        head_pc_q    <= bypass ? fpc_q        : pc_mem[rd_d];
        head_instr_q <= bypass ? imem_rdata_i : instr_mem[rd_d];
      end
      case (state_q)
        FETCH:   if (count_d == CW'(BUF_DEPTH)) state_q <= FULL;
        FULL:    if (count_d <  CW'(BUF_DEPTH)) state_q <= FETCH;
        FLUSH:   state_q <= FETCH;
        default: state_q <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: per-cycle vector table plus
// hand-written wrap/enable and asynchronous-reset sequences.

module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, ack, rdy, redir;
  logic [15:0] tgt;
  logic        req;
  logic [15:0] addr;
  logic [15:0] rdata;
  logic        vld;
  logic [15:0] instr;
  logic [15:0] ipc;

  logic        rst_w_n;
  logic        en_w, ack_w, rdy_w, redir_w;
  logic [7:0]  tgt_w;
  logic        req_w;
  logic [7:0]  addr_w;
  logic [15:0] rdata_w;
  logic        vld_w;
  logic [15:0] instr_w;
  logic [7:0]  ipc_w;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Memory model: returned instruction equals its address
  assign rdata   = addr;
  assign rdata_w = {8'h00, addr_w};

  instr_fetch_unit dut (
    .clk_i(clk), .arst_ni(rst_n), .enable_i(en),
    .imem_req_o(req), .imem_addr_o(addr), .imem_ack_i(ack), .imem_rdata_i(rdata),
    .redirect_i(redir), .redirect_pc_i(tgt),
    .instr_valid_o(vld), .instr_ready_i(rdy), .instr_o(instr), .instr_pc_o(ipc)
  );

  instr_fetch_unit #(.AW(8), .RESET_PC(8'hFE)) dut_w (
    .clk_i(clk), .arst_ni(rst_w_n), .enable_i(en_w),
    .imem_req_o(req_w), .imem_addr_o(addr_w), .imem_ack_i(ack_w), .imem_rdata_i(rdata_w),
    .redirect_i(redir_w), .redirect_pc_i(tgt_w),
    .instr_valid_o(vld_w), .instr_ready_i(rdy_w), .instr_o(instr_w), .instr_pc_o(ipc_w)
  );

  typedef struct {
    logic        en, ack, rdy, redir;
    logic [15:0] tgt;
    logic        req;
    logic [15:0] addr;
    logic        vld;
    logic [15:0] pc;
  } vec_t;

  localparam int NV = 29;
  vec_t vecs [NV];

  function automatic vec_t mk(logic e, logic a, logic r, logic d, logic [15:0] t,
                              logic q, logic [15:0] ad, logic v, logic [15:0] p);
    vec_t x;
    x.en = e; x.ack = a; x.rdy = r; x.redir = d; x.tgt = t;
    x.req = q; x.addr = ad; x.vld = v; x.pc = p;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    // straight-line fetch
    vecs[0]  = mk(1,1,1,0,16'h0,   1,16'h0000,0,16'h0000);
    vecs[1]  = mk(1,1,1,0,16'h0,   1,16'h0002,1,16'h0000);
    vecs[2]  = mk(1,1,1,0,16'h0,   1,16'h0004,1,16'h0002);
    vecs[3]  = mk(1,1,1,0,16'h0,   1,16'h0006,1,16'h0004);
    vecs[4]  = mk(1,1,1,0,16'h0,   1,16'h0008,1,16'h0006);
    // backpressure until full, single pop, refill
    vecs[5]  = mk(1,1,0,0,16'h0,   1,16'h000A,1,16'h0008);
    vecs[6]  = mk(1,1,0,0,16'h0,   1,16'h000C,1,16'h0008);
    vecs[7]  = mk(1,1,0,0,16'h0,   1,16'h000E,1,16'h0008);
    vecs[8]  = mk(1,1,0,0,16'h0,   0,16'h0010,1,16'h0008);
    vecs[9]  = mk(1,1,0,0,16'h0,   0,16'h0010,1,16'h0008);
    vecs[10] = mk(1,1,1,0,16'h0,   0,16'h0010,1,16'h0008);
    vecs[11] = mk(1,1,0,0,16'h0,   1,16'h0010,1,16'h000A);
    vecs[12] = mk(1,1,0,0,16'h0,   0,16'h0012,1,16'h000A);
    vecs[13] = mk(1,1,1,0,16'h0,   0,16'h0012,1,16'h000A);
    // redirect with 3 entries, simultaneous accept and pop
    vecs[14] = mk(1,1,1,1,16'h41,  1,16'h0012,1,16'h000C);
    vecs[15] = mk(1,1,1,0,16'h0,   0,16'h0040,0,16'h0000);
    vecs[16] = mk(1,1,1,0,16'h0,   1,16'h0040,0,16'h0000);
    vecs[17] = mk(1,1,1,0,16'h0,   1,16'h0042,1,16'h0040);
    // redirect, then redirect again while flushing
    vecs[18] = mk(1,1,1,1,16'h81,  1,16'h0044,1,16'h0042);
    vecs[19] = mk(1,1,1,1,16'h20,  0,16'h0080,0,16'h0000);
    vecs[20] = mk(1,1,1,0,16'h0,   0,16'h0020,0,16'h0000);
    // slow memory: ack every third cycle
    vecs[21] = mk(1,0,1,0,16'h0,   1,16'h0020,0,16'h0000);
    vecs[22] = mk(1,0,1,0,16'h0,   1,16'h0020,0,16'h0000);
    vecs[23] = mk(1,1,1,0,16'h0,   1,16'h0020,0,16'h0000);
    vecs[24] = mk(1,0,1,0,16'h0,   1,16'h0022,1,16'h0020);
    vecs[25] = mk(1,0,1,0,16'h0,   1,16'h0022,0,16'h0000);
    vecs[26] = mk(1,1,1,0,16'h0,   1,16'h0022,0,16'h0000);
    vecs[27] = mk(1,0,1,0,16'h0,   1,16'h0024,1,16'h0022);
    // enable low suppresses requests
    vecs[28] = mk(0,1,1,0,16'h0,   0,16'h0024,0,16'h0000);

    rst_n = 1'b0; en = 1'b1; ack = 1'b1; rdy = 1'b1; redir = 1'b0; tgt = '0;
    rst_w_n = 1'b0; en_w = 1'b0; ack_w = 1'b0; rdy_w = 1'b0; redir_w = 1'b0; tgt_w = '0;

    // reset state, with enable already high
    #1;
    chk("reset_req",   32'(req),   32'h0);
    chk("reset_addr",  32'(addr),  32'h0);
    chk("reset_valid", 32'(vld),   32'h0);
    chk("reset_instr", 32'(instr), 32'h0);
    chk("reset_pc",    32'(ipc),   32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NV; i++) begin
      if (i != 0) @(negedge clk);
      en = vecs[i].en; ack = vecs[i].ack; rdy = vecs[i].rdy;
      redir = vecs[i].redir; tgt = vecs[i].tgt;
      #1;
      chk($sformatf("v%0d_req", i),   32'(req),  32'(vecs[i].req));
      chk($sformatf("v%0d_addr", i),  32'(addr), 32'(vecs[i].addr));
      chk($sformatf("v%0d_valid", i), 32'(vld),  32'(vecs[i].vld));
      if (vecs[i].vld) begin
        chk($sformatf("v%0d_pc", i),    32'(ipc),   32'(vecs[i].pc));
        chk($sformatf("v%0d_instr", i), 32'(instr), 32'(vecs[i].pc));
      end
    end

    // asynchronous reset mid-burst: fill two entries, then reset between edges
    @(negedge clk);
    en = 1'b1; ack = 1'b1; rdy = 1'b0; redir = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("pre_rst_valid", 32'(vld), 32'h1);
    chk("pre_rst_pc",    32'(ipc), 32'h24);
    chk("pre_rst_addr",  32'(addr), 32'h28);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req",   32'(req),   32'h0);
    chk("arst_addr",  32'(addr),  32'h0);
    chk("arst_valid", 32'(vld),   32'h0);
    chk("arst_instr", 32'(instr), 32'h0);
    chk("arst_pc",    32'(ipc),   32'h0);
    @(negedge clk);
    rst_n = 1'b1; rdy = 1'b1;
    #1;
    chk("restart_req",  32'(req),  32'h1);
    chk("restart_addr", 32'(addr), 32'h0);
    @(negedge clk);
    #1;
    chk("restart_addr2", 32'(addr), 32'h2);
    chk("restart_valid", 32'(vld),  32'h1);
    chk("restart_pc",    32'(ipc),  32'h0);
    en = 1'b0;

    // wrap-around from RESET_PC = 0xFE, then drain with enable low
    @(negedge clk);
    rst_w_n = 1'b1; en_w = 1'b1; ack_w = 1'b1; rdy_w = 1'b0;
    #1;
    chk("wrap_addr0", 32'(addr_w), 32'hFE);
    chk("wrap_req0",  32'(req_w),  32'h1);
    @(negedge clk);
    #1;
    chk("wrap_addr1", 32'(addr_w), 32'h00);
    @(negedge clk);
    #1;
    chk("wrap_addr2", 32'(addr_w), 32'h02);
    @(negedge clk);
    en_w = 1'b0; rdy_w = 1'b1;
    #1;
    chk("drain0_req", 32'(req_w), 32'h0);
    chk("drain0_vld", 32'(vld_w), 32'h1);
    chk("drain0_pc",  32'(ipc_w), 32'hFE);
    chk("drain0_ins", 32'(instr_w), 32'h00FE);
    @(negedge clk);
    #1;
    chk("drain1_req", 32'(req_w), 32'h0);
    chk("drain1_pc",  32'(ipc_w), 32'h00);
    @(negedge clk);
    #1;
    chk("drain2_pc",   32'(ipc_w),   32'h02);
    chk("drain2_ins",  32'(instr_w), 32'h0002);
    chk("drain2_addr", 32'(addr_w),  32'h04);
    @(negedge clk);
    #1;
    chk("drain3_vld", 32'(vld_w), 32'h0);
    chk("drain3_req", 32'(req_w), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
